// File: rtl/clock_gen_core_if.sv
// Shared clock bus: system clock copy, lock flag and the ultrasound-period
// time base (strobe + phase) published to every downstream block.
interface clock_bus_if;
  logic       CLK;
  logic       LOCKED;
  logic       STROBE;
  logic [9:0] PHASE;

  modport out_port (output CLK, output LOCKED, output STROBE, output PHASE);
  modport in_port  (input  CLK, input  LOCKED, input  STROBE, input  PHASE);
endinterface

// File: rtl/clock_gen_core.sv
// Clock front end: oscillator pass-through, reset synchronizer, lock counter and
// ultrasound-period phase/strobe generator. Optional macro: CLOCK_FAST_LOCK_EN.
module clock_gen_core #(
  parameter int LOCK_CYCLES = 256,
  parameter int PERIOD_DIV  = 640
) (
  input  logic             MRCC_25P6M,
  input  logic             RST_N,
  output logic             CLK,
  output logic             LOCKED,
  clock_bus_if.out_port    CLOCK_BUS
);

`ifdef CLOCK_FAST_LOCK_EN
  localparam int LockEff = (LOCK_CYCLES < 16) ? LOCK_CYCLES : 16;
`else
  localparam int LockEff = LOCK_CYCLES;
`endif

  localparam logic [15:0] LockTgt  = 16'(LockEff);
  localparam logic [9:0]  PhaseMax = 10'(PERIOD_DIV - 1);

  logic       w_clk;
  logic       r_sync_meta;
  logic       r_rst_sync_n;
  logic [15:0] r_lock_cnt;
  logic       r_locked;
  logic [9:0] r_phase;
  logic       r_strobe;
  logic       w_lock_hit;
  logic       w_wrap;

  assign w_clk = MRCC_25P6M;

  // Async assert, sync release; rst_sync_n goes high on the 2nd edge after RST_N.
  always_ff @(posedge w_clk or negedge RST_N) begin
    if (!RST_N) begin
      r_sync_meta  <= 1'b0;
      r_rst_sync_n <= 1'b0;
    end else begin
      r_sync_meta  <= 1'b1;
      r_rst_sync_n <= r_sync_meta;
    end
  end

  assign w_lock_hit = (r_lock_cnt == LockTgt);
  assign w_wrap     = (r_phase == PhaseMax);

  // Lock counter saturates at the target; LOCKED is sticky until reset.
  always_ff @(posedge w_clk or negedge r_rst_sync_n) begin
    if (!r_rst_sync_n) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      if (!w_lock_hit) begin
        r_lock_cnt <= r_lock_cnt + 16'd1;
      end
      if (w_lock_hit) begin
        r_locked <= 1'b1;
      end
    end
  end

  // Strobe fires on the first locked cycle and on every wrap back to phase 0.
  always_ff @(posedge w_clk or negedge r_rst_sync_n) begin
    if (!r_rst_sync_n) begin
      r_phase  <= '0;
      r_strobe <= 1'b0;
    end else begin
      if (r_locked) begin
        r_phase <= w_wrap ? 10'd0 : r_phase + 10'd1;
      end else begin
        r_phase <= '0;
      end
      r_strobe <= (w_lock_hit && !r_locked) || (r_locked && w_wrap);
    end
  end

  assign CLK    = w_clk;
  assign LOCKED = r_locked;

  assign CLOCK_BUS.CLK    = w_clk;
  assign CLOCK_BUS.LOCKED = r_locked;
  assign CLOCK_BUS.STROBE = r_strobe;
  assign CLOCK_BUS.PHASE  = r_phase;

endmodule

// File: tb/tb_clock_gen_core.sv
// Directed bench for clock_gen_core: lock latency, phase/strobe period, reset
// glitch relock, system-time enable behaviour and a PERIOD_DIV=2 instance.
`timescale 1ns/1ps
module tb_clock_gen_core;

`ifdef CLOCK_FAST_LOCK_EN
  localparam int LOCK_EDGE = 19;
`else
  localparam int LOCK_EDGE = 259;
`endif
  localparam int LOCK_EDGE2 = 7;  // second instance: LOCK_CYCLES=4 -> 2+4+1

  logic mrcc = 1'b0;
  logic rst_n = 1'b0;
  logic clk_o, locked_o, clk2_o, locked2_o;

  clock_bus_if bus ();
  clock_bus_if bus2 ();

  clock_gen_core #(.LOCK_CYCLES(256), .PERIOD_DIV(640)) dut (
    .MRCC_25P6M(mrcc), .RST_N(rst_n), .CLK(clk_o), .LOCKED(locked_o), .CLOCK_BUS(bus.out_port)
  );

  clock_gen_core #(.LOCK_CYCLES(4), .PERIOD_DIV(2)) dut2 (
    .MRCC_25P6M(mrcc), .RST_N(rst_n), .CLK(clk2_o), .LOCKED(locked2_o), .CLOCK_BUS(bus2.out_port)
  );

  always #19.531 mrcc = ~mrcc;

  longint unsigned systime;
  always @(posedge mrcc or negedge rst_n) begin
    if (!rst_n) systime <= 64'd1;
    else if (locked_o) systime <= systime + 64'd1;
  end

  typedef struct {
    int         edge_n;
    logic       locked;
    logic [9:0] phase;
    logic       strobe;
  } vec_t;

  vec_t tbl[10];
  int checks = 0;
  int errors = 0;
  int bad_inv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Walks n_edges edges after a release, applying table rows up to max_row_edge.
  task automatic run_after_release(input int n_edges, input int max_row_edge, input bit full);
    bad_inv = 0;
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge mrcc);
      #1;
      for (int i = 0; i < 10; i++) begin
        if (tbl[i].edge_n == e && e <= max_row_edge) begin
          chk($sformatf("locked@%0d", e), locked_o, tbl[i].locked);
          chk($sformatf("phase@%0d", e), bus.PHASE, tbl[i].phase);
          chk($sformatf("strobe@%0d", e), bus.STROBE, tbl[i].strobe);
        end
      end
      if (clk_o !== 1'b1 || bus.CLK !== 1'b1) bad_inv++;
      if (bus.LOCKED !== locked_o) bad_inv++;
      if (locked_o !== (e >= LOCK_EDGE)) bad_inv++;
      if (locked_o && (bus.STROBE !== (bus.PHASE == 10'd0))) bad_inv++;
      if (!locked_o && (bus.STROBE !== 1'b0 || bus.PHASE !== 10'd0)) bad_inv++;
      if (full) begin
        if (e == LOCK_EDGE || e == LOCK_EDGE + 1 || e == LOCK_EDGE + 100 || e == LOCK_EDGE - 1)
          chk($sformatf("systime@%0d", e), systime,
              (e <= LOCK_EDGE) ? 64'd1 : 64'(1 + e - LOCK_EDGE));
        if (e >= LOCK_EDGE2 - 1 && e <= LOCK_EDGE2 + 4) begin
          chk($sformatf("div2_locked@%0d", e), locked2_o, (e >= LOCK_EDGE2));
          chk($sformatf("div2_phase@%0d", e), bus2.PHASE,
              (e >= LOCK_EDGE2) ? 64'((e - LOCK_EDGE2) % 2) : 64'd0);
          chk($sformatf("div2_strobe@%0d", e), bus2.STROBE,
              (e >= LOCK_EDGE2) ? 64'(((e - LOCK_EDGE2) % 2) == 0) : 64'd0);
        end
      end
      @(negedge mrcc);
      #1;
      if (clk_o !== 1'b0 || bus.CLK !== 1'b0) bad_inv++;
    end
    chk("invariants", bad_inv, 0);
  endtask

  initial begin
    tbl[0] = '{1,              1'b0, 10'd0,   1'b0};
    tbl[1] = '{LOCK_EDGE - 1,  1'b0, 10'd0,   1'b0};
    tbl[2] = '{LOCK_EDGE,      1'b1, 10'd0,   1'b1};
    tbl[3] = '{LOCK_EDGE + 1,  1'b1, 10'd1,   1'b0};
    tbl[4] = '{LOCK_EDGE + 2,  1'b1, 10'd2,   1'b0};
    tbl[5] = '{LOCK_EDGE + 639, 1'b1, 10'd639, 1'b0};
    tbl[6] = '{LOCK_EDGE + 640, 1'b1, 10'd0,   1'b1};
    tbl[7] = '{LOCK_EDGE + 641, 1'b1, 10'd1,   1'b0};
    tbl[8] = '{LOCK_EDGE + 1279, 1'b1, 10'd639, 1'b0};
    tbl[9] = '{LOCK_EDGE + 1280, 1'b1, 10'd0,   1'b1};

    rst_n = 1'b0;
    repeat (10) @(posedge mrcc);
    #1;
    chk("rst_locked", locked_o, 0);
    chk("rst_phase", bus.PHASE, 0);
    chk("rst_strobe", bus.STROBE, 0);
    chk("rst_clk_runs", clk_o, 1);
    chk("rst_systime", systime, 1);

    @(negedge mrcc);
    rst_n = 1'b1;
    run_after_release(LOCK_EDGE + 1300, LOCK_EDGE + 1300, 1'b1);

    // 5 ns glitch mid-period, between a rising and falling edge.
    @(posedge mrcc);
    #5;
    rst_n = 1'b0;
    #1;
    chk("glitch_locked", locked_o, 0);
    chk("glitch_bus_locked", bus.LOCKED, 0);
    chk("glitch_phase", bus.PHASE, 0);
    chk("glitch_strobe", bus.STROBE, 0);
    chk("glitch_div2_locked", locked2_o, 0);
    #4;
    rst_n = 1'b1;
    run_after_release(LOCK_EDGE + 3, LOCK_EDGE + 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_gen_core.md
# clock_gen_core

Clock-management front end of the FPGA. Takes the 25.6 MHz board oscillator on `MRCC_25P6M`, distributes it as the system clock `CLK`, and produces a lock indicator plus a 40 kHz ultrasound-period time base. All results are published on the shared clock bus. Every downstream block, including the system-time counter that increments only while `LOCKED` is high, treats `LOCKED` as its enable.

## Interface
- `LOCK_CYCLES`, default 256: number of `CLK` cycles after reset release before `LOCKED` asserts. Legal range 1..65535.
- `PERIOD_DIV`, default 640: `CLK` cycles per ultrasound period. At 25.6 MHz this gives 40 kHz. Legal range 2..1024.
- `MRCC_25P6M`  in  1: the one clock, 25.6 MHz oscillator.
- `RST_N`  in  1: reset, asynchronous, active-low.
- `CLK`  out  1: system clock, same frequency and phase as `MRCC_25P6M`.
- `LOCKED`  out  1: clocks stable; all outputs valid.
- `CLOCK_BUS`  `clock_bus_if.out_port`: drives four fields:
  - `CLK` (1): copy of `CLK`.
  - `LOCKED` (1): copy of `LOCKED`.
  - `STROBE` (1): one-cycle pulse per ultrasound period.
  - `PHASE` (10): position within the period, 0..`PERIOD_DIV`-1.

## Operation
- `CLK` is a buffered pass-through of `MRCC_25P6M`. It is not gated or reset and runs from time zero.
- Reset synchronizer:
  - Two flops clocked by `MRCC_25P6M`.
  - Asynchronous assertion on `RST_N` low, synchronous release.
  - Output `rst_sync_n`.
- Lock counter:
  - 16 bits, cleared while `rst_sync_n`=0.
  - Increments each cycle until it equals `LOCK_CYCLES`, then holds (saturates, no wrap).
  - `LOCKED` is a registered flag, set when the counter equals `LOCK_CYCLES`. It stays set until reset.
- Phase counter:
  - 10 bits, held at 0 while `LOCKED`=0.
  - While `LOCKED`=1, increments every cycle and wraps from `PERIOD_DIV`-1 to 0.
- `STROBE` is registered. It is 1 in exactly the cycle where `PHASE`==0 after a wrap, and also in the first locked cycle. Period between strobes is exactly `PERIOD_DIV` cycles.
- Reset during operation: `LOCKED`, `PHASE` and `STROBE` drop to 0 asynchronously. The full lock sequence then restarts after release.
- `RST_N` glitch shorter than one cycle: still forces a full reset, because assertion is asynchronous.

## Timing
- Reset values: `LOCKED`=0, `PHASE`=0, `STROBE`=0, lock counter 0. `CLK` is unaffected.
- Release latency:
  - `rst_sync_n` rises on the 2nd `MRCC_25P6M` rising edge after `RST_N` goes high.
  - `LOCKED` rises `LOCK_CYCLES`+1 edges after that: 2+`LOCK_CYCLES`+1 edges total.
- First locked edge: `STROBE`=1 and `PHASE`=0. Next edge: `PHASE`=1 and `STROBE`=0.
- `PHASE` sequence: 0,1,…,`PERIOD_DIV`-1,0. `STROBE`=1 concurrently with every `PHASE`=0.
- Bus fields are updated on the same edges as the discrete outputs, with zero skew between `LOCKED` and `CLOCK_BUS.LOCKED`.

## Configuration
- `CLOCK_FAST_LOCK_EN` defined: the effective lock count is min(`LOCK_CYCLES`, 16), for short simulations.
- Undefined: `LOCK_CYCLES` is used as given.
- No other behaviour changes.

## Test plan
- Reset held 10 cycles, then released, with defaults:
  - `LOCKED`=0 through edge 258.
  - `LOCKED`=1 at edge 259 after release and stays 1.
  - `CLK` toggles throughout at 39.0625 ns period.
- After lock with `PERIOD_DIV`=640:
  - `STROBE` pulses exactly every 640 cycles.
  - `PHASE` counts 0..639 and wraps to 0 together with `STROBE`.
- `RST_N` pulsed low for 5 ns mid-period:
  - `LOCKED`, `PHASE` and `STROBE` go to 0 immediately.
  - Relock occurs 259 edges after release.
- `CLOCK_FAST_LOCK_EN` defined, `LOCK_CYCLES`=256: `LOCKED` rises at edge 19 after release.
- Free-running 64-bit counter incremented on `CLK` when `LOCKED` (started at 1): value stays 1 until lock, then increases by exactly 1 per cycle.
- `PERIOD_DIV`=2: `PHASE` alternates 0,1, and `STROBE` is high every other cycle starting at the first locked cycle.
